// File: rtl/spi_port_arbiter_if.sv
// Bus bundle between the SPI port arbiter, its requesting clients and the
// shared SPI byte engine. All handshakes are toggle style: a request is
// outstanding while req differs from ack.
interface spi_port_arbiter_if #(
  parameter int CLIENTS = 3
);
  // client side
  logic [CLIENTS-1:0]   cli_req;
  logic [CLIENTS-1:0]   cli_ack;
  logic [CLIENTS-1:0]   cli_lock;
  logic [CLIENTS-1:0]   cli_speed;
  logic [8*CLIENTS-1:0] cli_d;
  logic [7:0]           cli_q;
  logic [CLIENTS-1:0]   grant;
  // engine side
  logic                 spi_req;
  logic                 spi_ack;
  logic                 spi_speed;
  logic [7:0]           spi_d;
  logic [7:0]           spi_q;

  // arbiter view
  modport master (
    input  cli_req, cli_lock, cli_speed, cli_d, spi_ack, spi_q,
    output cli_ack, cli_q, grant, spi_req, spi_speed, spi_d
  );

  // environment view (clients plus SPI engine)
  modport slave (
    output cli_req, cli_lock, cli_speed, cli_d, spi_ack, spi_q,
    input  cli_ack, cli_q, grant, spi_req, spi_speed, spi_d
  );
endinterface

// File: rtl/spi_port_arbiter.sv
// N-client arbiter in front of the single shared SPI byte engine.
// Fixed-priority or round-robin selection, per-client bus lock so that a
// multi-byte chip-select transaction is never interleaved, and an optional
// forced release of a lock that sits idle for too long.
module spi_port_arbiter #(
  parameter int CLIENTS      = 3,
  parameter int RR_MODE      = 0,
  parameter int LOCK_TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  spi_port_arbiter_if.master bus
);

  localparam int IDXW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;
  localparam int CNTW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (LOCK_TIMEOUT > 0);
  localparam logic [CNTW-1:0] CNT_LAST = (LOCK_TIMEOUT > 0) ? CNTW'(LOCK_TIMEOUT - 1) : '0;
  localparam logic [CNTW-1:0] CNT_MAX  = '1;
  localparam logic [IDXW-1:0] PTR_RST  = IDXW'(CLIENTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t               state_r,     state_nxt_s;
  logic [IDXW-1:0]      owner_r,     owner_nxt_s;
  logic [IDXW-1:0]      ptr_r,       ptr_nxt_s;
  logic [CLIENTS-1:0]   grant_r,     grant_nxt_s;
  logic [CLIENTS-1:0]   ack_r,       ack_nxt_s;
  logic [7:0]           q_r,         q_nxt_s;
  logic                 spi_req_r,   spi_req_nxt_s;
  logic                 spi_speed_r, spi_speed_nxt_s;
  logic [7:0]           spi_d_r,     spi_d_nxt_s;
  logic [CNTW-1:0]      cnt_r,       cnt_nxt_s;

  logic [CLIENTS-1:0]   pending_s;
  logic                 win_found_s;
  logic [IDXW-1:0]      win_idx_s;
  logic [IDXW-1:0]      src_idx_s;
  logic [7:0]           d_sel_s;
  logic                 sp_sel_s;
  logic                 owner_pend_s;
  logic                 owner_lock_s;
  logic                 timeout_hit_s;

  // Candidate for search step s (1..CLIENTS); step 1 has the highest priority.
  function automatic logic [IDXW-1:0] cand_idx(input logic [IDXW-1:0] ptr, input int s);
    int t;
    t = (RR_MODE != 0) ? ((int'(ptr) + s) % CLIENTS) : (s - 1);
    return IDXW'(t);
  endfunction

  function automatic logic [CLIENTS-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [CLIENTS-1:0] v;
    v = '0;
    for (int i = 0; i < CLIENTS; i++) v[i] = (idx == IDXW'(i));
    return v;
  endfunction

  function automatic logic [7:0] byte_of(input logic [8*CLIENTS-1:0] d, input logic [IDXW-1:0] idx);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < CLIENTS; i++) r = (idx == IDXW'(i)) ? d[8*i +: 8] : r;
    return r;
  endfunction

  assign pending_s     = bus.cli_req ^ ack_r;
  assign win_found_s   = |pending_s;
  assign owner_pend_s  = |(pending_s & grant_r);
  assign owner_lock_s  = |(bus.cli_lock & grant_r);
  assign timeout_hit_s = TMO_EN && (cnt_r == CNT_LAST);
  // In IDLE the byte comes from the new winner, in HOLD from the current owner.
  assign src_idx_s     = (state_r == ST_IDLE) ? win_idx_s : owner_r;
  assign d_sel_s       = byte_of(bus.cli_d, src_idx_s);
  assign sp_sel_s      = bus.cli_speed[src_idx_s];

  // Pick the winner: scan from the lowest-priority candidate so the best one overwrites.
  always_comb begin
    win_idx_s = '0;
    for (int s = CLIENTS; s >= 1; s--) begin
      win_idx_s = pending_s[cand_idx(ptr_r, s)] ? cand_idx(ptr_r, s) : win_idx_s;
    end
  end

  // Next-state and next-output logic of the arbitration FSM.
  always_comb begin
    state_nxt_s     = state_r;
    owner_nxt_s     = owner_r;
    ptr_nxt_s       = ptr_r;
    grant_nxt_s     = grant_r;
    ack_nxt_s       = ack_r;
    q_nxt_s         = q_r;
    spi_req_nxt_s   = spi_req_r;
    spi_speed_nxt_s = spi_speed_r;
    spi_d_nxt_s     = spi_d_r;
    cnt_nxt_s       = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          state_nxt_s     = ST_ISSUE;
          owner_nxt_s     = win_idx_s;
          ptr_nxt_s       = win_idx_s;
          grant_nxt_s     = onehot(win_idx_s);
          spi_d_nxt_s     = d_sel_s;
          spi_speed_nxt_s = sp_sel_s;
          cnt_nxt_s       = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        spi_req_nxt_s = ~spi_req_r;
        state_nxt_s   = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.spi_ack == spi_req_r) begin
          q_nxt_s   = bus.spi_q;
          ack_nxt_s = (ack_r & ~grant_r) | (bus.cli_req & grant_r);
          cnt_nxt_s = '0;
          if (owner_lock_s) begin
            state_nxt_s = ST_HOLD;
          end else begin
            grant_nxt_s = '0;
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        // A new byte from the owner wins over a simultaneous lock drop.
        if (owner_pend_s) begin
          spi_d_nxt_s     = d_sel_s;
          spi_speed_nxt_s = sp_sel_s;
          cnt_nxt_s       = '0;
          state_nxt_s     = ST_ISSUE;
        end else if (!owner_lock_s) begin
          grant_nxt_s = '0;
          cnt_nxt_s   = '0;
          state_nxt_s = ST_IDLE;
        end else if (timeout_hit_s) begin
          grant_nxt_s = '0;
          cnt_nxt_s   = '0;
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNTW'(1);
        end
      end
      default: begin
        grant_nxt_s = '0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any byte in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      owner_r     <= '0;
      ptr_r       <= PTR_RST;
      grant_r     <= '0;
      ack_r       <= '0;
      q_r         <= 8'h00;
      spi_req_r   <= 1'b0;
      spi_speed_r <= 1'b0;
      spi_d_r     <= 8'h00;
      cnt_r       <= '0;
    end else begin
      state_r     <= state_nxt_s;
      owner_r     <= owner_nxt_s;
      ptr_r       <= ptr_nxt_s;
      grant_r     <= grant_nxt_s;
      ack_r       <= ack_nxt_s;
      q_r         <= q_nxt_s;
      spi_req_r   <= spi_req_nxt_s;
      spi_speed_r <= spi_speed_nxt_s;
      spi_d_r     <= spi_d_nxt_s;
      cnt_r       <= cnt_nxt_s;
    end
  end

  assign bus.cli_ack   = ack_r;
  assign bus.cli_q     = q_r;
  assign bus.grant     = grant_r;
  assign bus.spi_req   = spi_req_r;
  assign bus.spi_speed = spi_speed_r;
  assign bus.spi_d     = spi_d_r;

endmodule

// File: tb/tb_spi_port_arbiter.sv
// Bench for spi_port_arbiter: instance 0 is fixed priority with a 16-cycle
// lock timeout, instance 1 is round-robin without timeout. A responder
// models the SPI engine with random latency and random receive bytes.
module tb_spi_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]  c_req [2];
  logic [2:0]  c_lock [2];
  logic [2:0]  c_speed [2];
  logic [23:0] c_d [2];
  logic        e_ack [2];
  logic [7:0]  e_q [2];
  logic        e_stall [2];
  int          e_wait [2];

  logic [2:0]  o_ack [2];
  logic [7:0]  o_q [2];
  logic [2:0]  o_grant [2];
  logic        o_spi_req [2];
  logic        o_spi_speed [2];
  logic [7:0]  o_spi_d [2];

  spi_port_arbiter_if #(.CLIENTS(3)) bus0 ();
  spi_port_arbiter_if #(.CLIENTS(3)) bus1 ();

  spi_port_arbiter #(.CLIENTS(3), .RR_MODE(0), .LOCK_TIMEOUT(16)) dut0 (
    .clk(clk), .reset_n(rst_n), .bus(bus0.master));
  spi_port_arbiter #(.CLIENTS(3), .RR_MODE(1), .LOCK_TIMEOUT(0)) dut1 (
    .clk(clk), .reset_n(rst_n), .bus(bus1.master));

  assign bus0.cli_req = c_req[0];   assign bus1.cli_req = c_req[1];
  assign bus0.cli_lock = c_lock[0]; assign bus1.cli_lock = c_lock[1];
  assign bus0.cli_speed = c_speed[0]; assign bus1.cli_speed = c_speed[1];
  assign bus0.cli_d = c_d[0];       assign bus1.cli_d = c_d[1];
  assign bus0.spi_ack = e_ack[0];   assign bus1.spi_ack = e_ack[1];
  assign bus0.spi_q = e_q[0];       assign bus1.spi_q = e_q[1];
  assign o_ack[0] = bus0.cli_ack;   assign o_ack[1] = bus1.cli_ack;
  assign o_q[0] = bus0.cli_q;       assign o_q[1] = bus1.cli_q;
  assign o_grant[0] = bus0.grant;   assign o_grant[1] = bus1.grant;
  assign o_spi_req[0] = bus0.spi_req; assign o_spi_req[1] = bus1.spi_req;
  assign o_spi_speed[0] = bus0.spi_speed; assign o_spi_speed[1] = bus1.spi_speed;
  assign o_spi_d[0] = bus0.spi_d;   assign o_spi_d[1] = bus1.spi_d;

  typedef struct { int inst; int cli; logic [7:0] d; logic sp; logic [7:0] q; } rec_t;
  typedef struct { int inst; int cli; logic [7:0] q; logic [2:0] g; } ev_t;
  rec_t recs[$];
  ev_t  acks[$];

  logic [8:0] issued [6][32];
  int iss_wr [6];
  int iss_rd [6];
  int exp_ord [16];
  logic [2:0] exp_g [16];
  int exp_n;
  int n_tests = 0;
  int n_fail = 0;

  function automatic int onehot_idx(input logic [2:0] g);
    for (int i = 0; i < 3; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Reference arbitration: fixed = lowest index, RR = first after ptr.
  function automatic int pick(input logic [2:0] mask, input bit rr, input int ptr);
    int idx;
    for (int s = 1; s <= 3; s++) begin
      idx = rr ? (ptr + s) % 3 : s - 1;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  // SPI engine model: answers each byte after 1..4 cycles, logs what it saw.
  initial begin
    rec_t r;
    for (int k = 0; k < 2; k++) begin e_ack[k] = 1'b0; e_q[k] = 8'h00; e_wait[k] = 0; end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          e_ack[k] = 1'b0; e_wait[k] = 0;
        end else if (o_spi_req[k] !== e_ack[k] && !e_stall[k]) begin
          if (e_wait[k] == 0) e_wait[k] = $urandom_range(4, 1);
          e_wait[k]--;
          if (e_wait[k] == 0) begin
            r.inst = k; r.cli = onehot_idx(o_grant[k]); r.d = o_spi_d[k];
            r.sp = o_spi_speed[k]; r.q = 8'($urandom);
            e_q[k] = r.q; e_ack[k] = o_spi_req[k];
            recs.push_back(r);
          end
        end
      end
    end
  end

  // Ack monitor: logs every client ack change with the shared cli_q and grant.
  initial begin
    logic [2:0] prev [2];
    ev_t ev;
    prev[0] = 3'b000; prev[1] = 3'b000;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst_n) begin
          for (int i = 0; i < 3; i++) begin
            if (o_ack[k][i] !== prev[k][i]) begin
              ev.inst = k; ev.cli = i; ev.q = o_q[k]; ev.g = o_grant[k];
              acks.push_back(ev);
            end
          end
        end
        prev[k] = o_ack[k];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int k, input int i, input logic [7:0] d, input logic sp);
    int slot;
    slot = k * 3 + i;
    c_d[k][8*i +: 8] = d;
    c_speed[k][i] = sp;
    c_req[k][i] = ~c_req[k][i];
    issued[slot][iss_wr[slot] % 32] = {sp, d};
    iss_wr[slot]++;
  endtask

  task automatic wait_ack(input int k, input int i);
    int n;
    n = 0;
    while (o_ack[k][i] !== c_req[k][i] && n < 200) begin @(negedge clk); n++; end
    chk($sformatf("ack_wait_i%0d_c%0d", k, i), 32'(n >= 200), 32'd0);
  endtask

  task automatic wait_done(input int k);
    int n;
    n = 0;
    while ((o_ack[k] !== c_req[k] || o_grant[k] !== 3'b000 || o_spi_req[k] !== e_ack[k]) && n < 300) begin
      @(negedge clk); n++;
    end
    chk($sformatf("done_wait_i%0d", k), 32'(n >= 300), 32'd0);
  endtask

  task automatic serve_check(input int k);
    rec_t r;
    ev_t a;
    int slot;
    for (int j = 0; j < exp_n; j++) begin
      if (recs.size() == 0 || acks.size() == 0) begin
        chk("bytes_served", 32'(j), 32'(exp_n));
        break;
      end
      r = recs.pop_front();
      a = acks.pop_front();
      slot = k * 3 + exp_ord[j];
      chk("served_inst", 32'(r.inst), 32'(k));
      chk($sformatf("served_client_%0d", j), 32'(r.cli), 32'(exp_ord[j]));
      chk("spi_d", 32'(r.d), 32'(issued[slot][iss_rd[slot] % 32][7:0]));
      chk("spi_speed", 32'(r.sp), 32'(issued[slot][iss_rd[slot] % 32][8]));
      iss_rd[slot]++;
      chk($sformatf("ack_client_%0d", j), 32'(a.cli), 32'(exp_ord[j]));
      chk("cli_q", 32'(a.q), 32'(r.q));
      chk("grant_at_ack", 32'(a.g), 32'(exp_g[j]));
    end
    chk("extra_bytes", 32'(recs.size()), 32'd0);
    chk("extra_acks", 32'(acks.size()), 32'd0);
    chk("ack_eq_req", 32'(o_ack[k]), 32'(c_req[k]));
  endtask

  task automatic check_zero(input int k, input string tag);
    chk({tag, "_cli_ack"}, 32'(o_ack[k]), 32'd0);
    chk({tag, "_cli_q"}, 32'(o_q[k]), 32'd0);
    chk({tag, "_grant"}, 32'(o_grant[k]), 32'd0);
    chk({tag, "_spi_req"}, 32'(o_spi_req[k]), 32'd0);
    chk({tag, "_spi_speed"}, 32'(o_spi_speed[k]), 32'd0);
    chk({tag, "_spi_d"}, 32'(o_spi_d[k]), 32'd0);
  endtask

  initial begin
    logic r0, r1;
    logic [2:0] mask;
    int w, ptr, n;
    int sent [3];
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      c_req[k] = 3'b000; c_lock[k] = 3'b000; c_speed[k] = 3'b000; c_d[k] = 24'h0; e_stall[k] = 1'b0;
    end
    for (int s = 0; s < 6; s++) begin iss_wr[s] = 0; iss_rd[s] = 0; end

    repeat (3) @(negedge clk);
    check_zero(0, "reset0");
    check_zero(1, "reset1");
    rst_n = 1'b1;
    @(negedge clk);

    // single byte with 2-clock issue latency
    r0 = o_spi_req[0];
    r1 = ~r0;
    req(0, 1, 8'hA5, 1'b1);
    @(posedge clk); #1;
    chk("lat1_spi_req", 32'(o_spi_req[0]), 32'(r0));
    chk("lat1_grant", 32'(o_grant[0]), 32'h2);
    chk("lat1_spi_d", 32'(o_spi_d[0]), 32'hA5);
    chk("lat1_spi_speed", 32'(o_spi_speed[0]), 32'h1);
    @(posedge clk); #1;
    chk("lat2_spi_req", 32'(o_spi_req[0]), 32'(r1));
    @(negedge clk);
    wait_done(0);
    exp_ord[0] = 1; exp_g[0] = 3'b000; exp_n = 1;
    serve_check(0);

    // fixed priority: clients 0 and 2 together, four times
    for (int rep = 0; rep < 4; rep++) begin
      @(negedge clk);
      req(0, 0, 8'($urandom), 1'($urandom));
      req(0, 2, 8'($urandom), 1'($urandom));
      mask = 3'b101; exp_n = 0;
      while (mask != 3'b000) begin
        w = pick(mask, 1'b0, 0);
        exp_ord[exp_n] = w; exp_g[exp_n] = 3'b000; exp_n++;
        mask[w] = 1'b0;
      end
      wait_done(0);
      serve_check(0);
    end

    // round-robin: all three clients pending continuously for six bytes
    ptr = 2;
    for (int j = 0; j < 6; j++) begin
      w = pick(3'b111, 1'b1, ptr);
      ptr = w; exp_ord[j] = w; exp_g[j] = 3'b000;
    end
    exp_n = 6;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin req(1, i, 8'($urandom), 1'($urandom)); sent[i] = 1; end
    n = 0;
    while (n < 400) begin
      @(negedge clk); n++;
      for (int i = 0; i < 3; i++) begin
        if (o_ack[1][i] === c_req[1][i] && sent[i] < 2) begin
          req(1, i, 8'($urandom), 1'($urandom)); sent[i]++;
        end
      end
      if (sent[0] == 2 && sent[1] == 2 && sent[2] == 2 &&
          o_ack[1] === c_req[1] && o_grant[1] === 3'b000) break;
    end
    chk("rr_wait", 32'(n >= 400), 32'd0);
    serve_check(1);

    // lock: four back-to-back client-2 bytes, client 0 waits; last toggle drops lock
    @(negedge clk);
    c_lock[0][2] = 1'b1;
    req(0, 2, 8'($urandom), 1'($urandom));
    wait_ack(0, 2);
    req(0, 2, 8'($urandom), 1'($urandom));
    req(0, 0, 8'($urandom), 1'($urandom));
    wait_ack(0, 2);
    req(0, 2, 8'($urandom), 1'($urandom));
    wait_ack(0, 2);
    req(0, 2, 8'($urandom), 1'($urandom));
    c_lock[0][2] = 1'b0;
    wait_done(0);
    exp_ord[0] = 2; exp_ord[1] = 2; exp_ord[2] = 2; exp_ord[3] = 2; exp_ord[4] = 0;
    exp_g[0] = 3'b100; exp_g[1] = 3'b100; exp_g[2] = 3'b100; exp_g[3] = 3'b000; exp_g[4] = 3'b000;
    exp_n = 5;
    serve_check(0);

    // lock timeout: release exactly 16 cycles after entering HOLD
    @(negedge clk);
    c_lock[0][2] = 1'b1;
    req(0, 2, 8'($urandom), 1'($urandom));
    wait_ack(0, 2);
    req(0, 1, 8'($urandom), 1'($urandom));
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (c == 15) chk("tmo_hold_15", 32'(o_grant[0]), 32'h4);
      if (c == 16) chk("tmo_release_16", 32'(o_grant[0]), 32'h0);
    end
    @(negedge clk);
    wait_done(0);
    c_lock[0][2] = 1'b0;
    exp_ord[0] = 2; exp_ord[1] = 1; exp_g[0] = 3'b100; exp_g[1] = 3'b000; exp_n = 2;
    serve_check(0);

    // asynchronous reset while the engine is still busy
    @(negedge clk);
    e_stall[0] = 1'b1;
    req(0, 0, 8'($urandom), 1'($urandom));
    repeat (4) @(posedge clk);
    #1;
    chk("rst_pre_grant", 32'(o_grant[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_zero(0, "async_rst");
    for (int k = 0; k < 2; k++) begin c_req[k] = 3'b000; c_lock[k] = 3'b000; end
    for (int s = 0; s < 6; s++) begin iss_wr[s] = 0; iss_rd[s] = 0; end
    e_stall[0] = 1'b0;
    repeat (2) @(negedge clk);
    recs.delete();
    acks.delete();
    rst_n = 1'b1;
    @(negedge clk);
    req(0, 1, 8'($urandom), 1'($urandom));
    wait_done(0);
    exp_ord[0] = 1; exp_g[0] = 3'b000; exp_n = 1;
    serve_check(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_port_arbiter.md
Name: spi_port_arbiter

Overview:
Parametrised N-client arbiter in front of the single shared SPI byte engine. It generalises the fixed two-way flash/mmc64 request mux in the chameleon2 top level to CLIENTS requestors, with fixed-priority or round-robin selection. It adds per-client bus lock, so a multi-byte chip-select transaction is never interleaved, and an optional lock timeout. All client and engine interfaces use the codebase toggle handshake: a request is pending while req != ack.

Parameters:
CLIENTS, 3, number of requestors (1..8); index 0 has the highest fixed priority.
RR_MODE, 0, 0 = fixed priority (lowest pending index wins); 1 = round-robin, starting after the last granted client.
LOCK_TIMEOUT, 0, idle cycles in HOLD before a locked grant is forcibly released; 0 disables the timeout.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cli_req  in  CLIENTS  per-client toggle request
cli_ack  out  CLIENTS  per-client toggle acknowledge
cli_lock  in  CLIENTS  client keeps ownership after its byte completes while high
cli_speed  in  CLIENTS  per-client SPI speed select
cli_d  in  8*CLIENTS  per-client transmit byte; client i occupies bits [8i+7:8i]
cli_q  out  8  received byte, shared by all clients; valid for the owner when its ack toggles
grant  out  CLIENTS  one-hot current owner; zero when IDLE
spi_req  out  1  toggle request to the SPI engine
spi_ack  in  1  toggle acknowledge from the SPI engine
spi_speed  out  1  registered speed for the current byte
spi_d  out  8  registered transmit byte
spi_q  in  8  byte received by the SPI engine

Behaviour:
- Reset values (async, reset_n=0): cli_ack=0, cli_q=0, grant=0, spi_req=0, spi_speed=0, spi_d=0, state=IDLE, RR pointer=CLIENTS-1, timeout counter=0. Reset mid-transfer abandons the byte; the SPI engine shares the reset, so its spi_ack also returns to 0.
- Definitions: pending[i] = cli_req[i] ^ cli_ack[i]. Engine busy = spi_req ^ spi_ack.
- IDLE: if any client is pending, pick winner w per RR_MODE. Next edge: grant=onehot(w), spi_d=cli_d[w], spi_speed=cli_speed[w], state=ISSUE. No pending client means stay in IDLE.
- ISSUE: toggle spi_req, go to WAIT. Latency from pending to spi_req toggle is 2 clocks.
- WAIT: when spi_ack==spi_req, on that edge cli_q<=spi_q and cli_ack[w]<=cli_req[w]. Then:
  - if cli_lock[w]=1, go to HOLD;
  - otherwise grant<=0 and go to IDLE.
- HOLD: grant is kept and the counter increments each cycle.
  - pending[w]: latch cli_d[w]/cli_speed[w], clear the counter, go to ISSUE. Other clients are ignored.
  - else if cli_lock[w]=0: grant<=0, go to IDLE.
  - else if LOCK_TIMEOUT>0 and counter==LOCK_TIMEOUT-1: grant<=0, go to IDLE (forced release).
- Round-robin: the pointer updates to w when leaving IDLE. Search order is ptr+1 .. ptr+CLIENTS, modulo CLIENTS.
- Simultaneous events:
  - A new pending on another client during WAIT or HOLD waits; it is serviced from IDLE.
  - A lock dropped in the same cycle the owner's next req toggles is treated as pending: service the byte first, then check lock again after WAIT.
- Protocol rules:
  - A client must not toggle req again while pending; a second toggle cancels the pending state and is not detected.
  - Clients that are not the owner see no ack change.
  - cli_d/cli_speed are sampled only at the IDLE->ISSUE or HOLD->ISSUE edge; later changes do not affect the byte in flight.
- Counter width: clog2(LOCK_TIMEOUT+1), saturating. The counter is unused when LOCK_TIMEOUT=0.
- CLIENTS=1 degenerates to a registered pass-through with 2-clock issue latency; grant is 1 while active.

Test Plan:
- Single byte: client 1 toggles req with d=0xA5, speed=1 -> 2 clocks later spi_req toggles, spi_d=0xA5, spi_speed=1. Engine acks with q=0x3C -> cli_q=0x3C, cli_ack[1] toggles, grant returns to 0.
- Fixed priority: RR_MODE=0, clients 0 and 2 pending in the same cycle -> client 0 served first, then client 2. Repeat 4 times -> client 2 is always served second.
- Round-robin: RR_MODE=1, all 3 clients pending continuously for 6 bytes -> grant order 0,1,2,0,1,2.
- Lock: client 2 locked for 4 bytes while client 0 toggles req after byte 1 -> all 4 client-2 bytes are back-to-back. Client 0 is granted only after client 2 drops its lock.
- Timeout: LOCK_TIMEOUT=16, owner holds lock with no new req -> grant released exactly 16 cycles after entering HOLD, and a pending client 1 is then served.
- Async reset: assert reset_n low during WAIT -> all outputs are 0 immediately, without waiting for a clock edge. After release, a new request completes normally.
